// File: rtl/rv_prog_loader.sv
// ============================================================================
// rv_prog_loader : framed byte-stream loader for risc_v IM/DM preload + reset
// Rev 1.0
// ============================================================================
`default_nettype none

module rv_prog_loader #(
  parameter int RST_HOLD = 4,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          cpu_rst,
  output logic          im_ld,
  output logic [31:0]   im_wd,
  output logic [AW-1:0] im_a,
  output logic          dm_ld,
  output logic [31:0]   dm_wd,
  output logic [AW-1:0] dm_a,
  output logic          err,
  output logic [15:0]   im_cnt,
  output logic [15:0]   dm_cnt
);

  typedef enum logic [2:0] {
    S_CMD     = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  localparam logic [7:0] C_CMD_IM     = 8'h01;
  localparam logic [7:0] C_CMD_DM     = 8'h02;
  localparam logic [7:0] C_CMD_START  = 8'h03;
  localparam logic [7:0] C_CMD_RELOAD = 8'hFF;
  localparam logic [7:0] C_HOLD_INIT  = 8'(RST_HOLD - 1);

  state_t        state_q;
  logic [1:0]    idx_q;
  logic          tgt_dm_q;
  logic [31:0]   addr_q;
  logic [23:0]   data_q;
  logic [7:0]    hold_q;
  logic          in_ready_q;
  logic          cpu_rst_q;
  logic          im_ld_q;
  logic          dm_ld_q;
  logic [31:0]   im_wd_q;
  logic [AW-1:0] im_a_q;
  logic [31:0]   dm_wd_q;
  logic [AW-1:0] dm_a_q;
  logic          err_q;
  logic [15:0]   im_cnt_q;
  logic [15:0]   dm_cnt_q;

  logic          xfer;
  logic [31:0]   word_d;

  assign xfer   = in_valid & in_ready_q;
  // Last data byte arrives on the commit edge, so the word is completed combinationally.
  assign word_d = {in_data, data_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CMD;
      idx_q      <= 2'd0;
      tgt_dm_q   <= 1'b0;
      addr_q     <= 32'd0;
      data_q     <= 24'd0;
      hold_q     <= 8'd0;
      in_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      im_ld_q    <= 1'b1;
      dm_ld_q    <= 1'b1;
      im_wd_q    <= 32'd0;
      im_a_q     <= '0;
      dm_wd_q    <= 32'd0;
      dm_a_q     <= '0;
      err_q      <= 1'b0;
      im_cnt_q   <= 16'd0;
      dm_cnt_q   <= 16'd0;
    end else begin
      in_ready_q <= 1'b1;
      case (state_q)
        S_CMD: begin
          if (xfer) begin
            if (in_data == C_CMD_IM || in_data == C_CMD_DM) begin
              state_q  <= S_ADDR;
              idx_q    <= 2'd0;
              tgt_dm_q <= in_data[1];
            end else if (in_data == C_CMD_START) begin
              state_q    <= S_RELEASE;
              im_ld_q    <= 1'b0;
              dm_ld_q    <= 1'b0;
              hold_q     <= C_HOLD_INIT;
              in_ready_q <= 1'b0;
            end else if (in_data != C_CMD_RELOAD) begin
              err_q <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (xfer) begin
            addr_q <= {in_data, addr_q[31:8]};
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            data_q <= {in_data, data_q[23:8]};
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q <= S_CMD;
              if (addr_q[1:0] != 2'b00) begin
                err_q <= 1'b1;
              end else if (tgt_dm_q) begin
                dm_a_q  <= AW'(addr_q);
                dm_wd_q <= word_d;
                if (dm_cnt_q != 16'hFFFF) dm_cnt_q <= dm_cnt_q + 16'd1;
              end else begin
                im_a_q  <= AW'(addr_q);
                im_wd_q <= word_d;
                if (im_cnt_q != 16'hFFFF) im_cnt_q <= im_cnt_q + 16'd1;
              end
            end
          end
        end
        S_RELEASE: begin
          if (hold_q == 8'd0) begin
            cpu_rst_q <= 1'b0;
            state_q   <= S_RUN;
          end else begin
            hold_q     <= hold_q - 8'd1;
            in_ready_q <= 1'b0;
          end
        end
        S_RUN: begin
          // Buses are left alone so the reload simply rewrites the last words.
          if (xfer && in_data == C_CMD_RELOAD) begin
            cpu_rst_q <= 1'b1;
            im_ld_q   <= 1'b1;
            dm_ld_q   <= 1'b1;
            im_cnt_q  <= 16'd0;
            dm_cnt_q  <= 16'd0;
            state_q   <= S_CMD;
          end
        end
        default: state_q <= S_CMD;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign cpu_rst  = cpu_rst_q;
  assign im_ld    = im_ld_q;
  assign im_wd    = im_wd_q;
  assign im_a     = im_a_q;
  assign dm_ld    = dm_ld_q;
  assign dm_wd    = dm_wd_q;
  assign dm_a     = dm_a_q;
  assign err      = err_q;
  assign im_cnt   = im_cnt_q;
  assign dm_cnt   = dm_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_prog_loader.sv
// ============================================================================
// tb_rv_prog_loader : randomized scoreboard bench for rv_prog_loader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rv_prog_loader;

  localparam int RST_HOLD = 4;
  localparam int AW       = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          cpu_rst;
  logic          im_ld;
  logic [31:0]   im_wd;
  logic [AW-1:0] im_a;
  logic          dm_ld;
  logic [31:0]   dm_wd;
  logic [AW-1:0] dm_a;
  logic          err;
  logic [15:0]   im_cnt;
  logic [15:0]   dm_cnt;

  rv_prog_loader #(.RST_HOLD(RST_HOLD), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cpu_rst(cpu_rst), .im_ld(im_ld), .im_wd(im_wd), .im_a(im_a),
    .dm_ld(dm_ld), .dm_wd(dm_wd), .dm_a(dm_a), .err(err),
    .im_cnt(im_cnt), .dm_cnt(dm_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        in_ready;
    logic        cpu_rst;
    logic        im_ld;
    logic        dm_ld;
    logic        err;
    logic [15:0] im_cnt;
    logic [15:0] dm_cnt;
    logic [31:0] im_a;
    logic [31:0] im_wd;
    logic [31:0] dm_a;
    logic [31:0] dm_wd;
  } snap_t;

  int n_tests = 0;
  int n_fail  = 0;
  bit stall_mode = 1'b0;

  // Reference model: frame-level view of the protocol.
  snap_t       cur;
  bit          m_run;
  logic [7:0]  m_frame[$];
  snap_t       exp_q[$];
  logic [31:0] im_exp[int];
  logic [31:0] dm_exp[int];

  // Memories behaving as the core's IM/DM during preload.
  logic [31:0] im_mem[int];
  logic [31:0] dm_mem[int];

  always @(posedge clk) begin
    if (im_ld === 1'b1) im_mem[int'({2'b00, im_a[31:2]})] = im_wd;
    if (dm_ld === 1'b1) dm_mem[int'({2'b00, dm_a[31:2]})] = dm_wd;
  end

  function automatic snap_t dut_snap();
    snap_t s;
    s.in_ready = in_ready; s.cpu_rst = cpu_rst; s.im_ld = im_ld; s.dm_ld = dm_ld;
    s.err = err; s.im_cnt = im_cnt; s.dm_cnt = dm_cnt;
    s.im_a = im_a; s.im_wd = im_wd; s.dm_a = dm_a; s.dm_wd = dm_wd;
    return s;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_snap(input string name);
    snap_t a;
    a = dut_snap();
    n_tests++;
    if (a !== cur) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (rdy,crst,imld,dmld,err,imcnt,dmcnt,ima,imwd,dma,dmwd)",
               name, a, cur);
    end
  endtask

  task automatic model_reset();
    cur = '0;
    cur.cpu_rst = 1'b1;
    cur.im_ld   = 1'b1;
    cur.dm_ld   = 1'b1;
    m_run = 1'b0;
    m_frame.delete();
    exp_q.delete();
    im_exp[0] = 32'd0;
    dm_exp[0] = 32'd0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] a, d;
    bit          started;
    started = 1'b0;
    cur.in_ready = 1'b1;
    if (m_run) begin
      if (b == 8'hFF) begin
        m_run = 1'b0;
        cur.cpu_rst = 1'b1; cur.im_ld = 1'b1; cur.dm_ld = 1'b1;
        cur.im_cnt = 16'd0; cur.dm_cnt = 16'd0;
      end
    end else if (m_frame.size() == 0) begin
      if (b == 8'h01 || b == 8'h02) m_frame.push_back(b);
      else if (b == 8'h03) begin
        started = 1'b1;
        cur.im_ld = 1'b0; cur.dm_ld = 1'b0; cur.in_ready = 1'b0;
      end else if (b != 8'hFF) cur.err = 1'b1;
    end else begin
      m_frame.push_back(b);
      if (m_frame.size() == 9) begin
        a = {m_frame[4], m_frame[3], m_frame[2], m_frame[1]};
        d = {m_frame[8], m_frame[7], m_frame[6], m_frame[5]};
        if (a % 4 != 0) cur.err = 1'b1;
        else if (m_frame[0] == 8'h01) begin
          cur.im_a = a; cur.im_wd = d;
          if (cur.im_cnt != 16'hFFFF) cur.im_cnt = cur.im_cnt + 16'd1;
          im_exp[int'(a / 4)] = d;
        end else begin
          cur.dm_a = a; cur.dm_wd = d;
          if (cur.dm_cnt != 16'hFFFF) cur.dm_cnt = cur.dm_cnt + 16'd1;
          dm_exp[int'(a / 4)] = d;
        end
        m_frame.delete();
      end
    end
    exp_q.push_back(cur);
    if (started) begin
      // Next observable byte can only be taken once the core is running.
      m_run = 1'b1;
      cur.cpu_rst = 1'b0;
      cur.in_ready = 1'b1;
    end
  endtask

  // Monitor: every accepted byte must match the next scoreboard entry.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) begin
      #1;
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_accept actual=byte %h taken required=no transfer", in_data);
      end else begin
        snap_t e, a;
        e = exp_q.pop_front();
        a = dut_snap();
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL byte_snapshot actual=%h required=%h (rdy,crst,imld,dmld,err,imcnt,dmcnt,ima,imwd,dma,dmwd)",
                   a, e);
        end
      end
    end
  end

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap, w;
    gap = stall_mode ? 1 : (($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    model_byte(b);
    w = 0;
    while (in_ready !== 1'b1) begin
      if (w >= 2000) begin
        n_tests++; n_fail++;
        $display("FAIL ready_timeout actual=in_ready low for %0d cycles required=in_ready high", w);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "loader stalled");
      end
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #2;
    chk_snap(name);
    @(negedge clk);
    rst = 1'b0;
    cur.in_ready = 1'b1;
    @(negedge clk);
    chk_snap({name, "_release"});
  endtask

  task automatic do_start();
    int  cycles;
    bit  bad;
    send_byte(8'h03);
    cycles = 0;
    bad = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    while (in_ready !== 1'b1 && cycles < 300) begin
      cycles++;
      if (cpu_rst !== 1'b1 || im_ld !== 1'b0 || dm_ld !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk(cycles == RST_HOLD && !bad && cpu_rst === 1'b0, "start_hold",
        {31'd0, bad, cpu_rst, 31'(cycles)}, {33'd0, 31'(RST_HOLD)});
  endtask

  task automatic random_frames(input int n);
    int          r;
    logic [7:0]  c;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      r = int'($urandom % 10);
      a = 32'($urandom_range(0, 31)) * 32'd4;
      if (r <= 3) send_frame(8'h01, a, $urandom);
      else if (r <= 6) send_frame(8'h02, a, $urandom);
      else if (r == 7) send_frame((($urandom % 2) == 0) ? 8'h01 : 8'h02,
                                  a + 32'($urandom_range(1, 3)), $urandom);
      else if (r == 8) send_byte(8'hFF);
      else begin
        c = 8'($urandom);
        while (c == 8'h01 || c == 8'h02 || c == 8'h03 || c == 8'hFF) c = 8'($urandom);
        send_byte(c);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_snap("reset_state");
    rst = 1'b0;
    cur.in_ready = 1'b1;
    @(negedge clk);
    chk_snap("reset_release");

    send_frame(8'h01, 32'h0000_0000, 32'h0000_0413);
    send_frame(8'h01, 32'h0000_0030, 32'h0920_2623);
    stall_mode = 1'b1;
    send_frame(8'h02, 32'h0000_0020, 32'hFFFF_FFF5);
    stall_mode = 1'b0;
    send_frame(8'h01, 32'h0000_0002, 32'hDDCC_BBAA);
    send_byte(8'h55);
    send_frame(8'h02, 32'h0000_0024, 32'h1234_5678);

    random_frames(60);

    for (int i = 0; i < 13; i++) send_frame(8'h01, 32'(i * 4), $urandom);
    for (int i = 0; i < 10; i++) send_frame(8'h02, 32'(i * 4), 32'($urandom_range(0, 1000)));
    do_start();

    send_byte(8'h10);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 254)));
    send_byte(8'hFF);

    random_frames(25);
    do_start();
    send_byte(8'h03);
    send_byte(8'hFF);

    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
    do_reset("midframe_reset");
    send_frame(8'h01, 32'h0000_0044, 32'hCAFE_F00D);
    send_frame(8'h02, 32'h0000_0008, 32'h0BAD_BEEF);

    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'd0);

    foreach (im_exp[k]) begin
      chk(im_mem.exists(k) && im_mem[k] === im_exp[k], "im_mem",
          {32'(k), im_mem.exists(k) ? im_mem[k] : 32'hDEAD_DEAD}, {32'(k), im_exp[k]});
    end
    foreach (dm_exp[k]) begin
      chk(dm_mem.exists(k) && dm_mem[k] === dm_exp[k], "dm_mem",
          {32'(k), dm_mem.exists(k) ? dm_mem[k] : 32'hDEAD_DEAD}, {32'(k), dm_exp[k]});
    end

    finish_run();
  end

  initial begin
    #2000000;
    n_tests++; n_fail++;
    $display("FAIL global_timeout actual=still running required=finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
